// File: rtl/qsgmii_lane_align_ctrl_if.sv
// QSGMII RX word stream into the lane aligner and the alignment status it
// returns to the splitter and per-port PCS link logic.
interface qsgmii_lane_align_ctrl_if;
    logic        rx_data_valid;
    logic [3:0]  rx_data_is_ctl;
    logic [31:0] rx_data;
    logic [3:0]  rx_symbol_err;
    logic [3:0]  rx_disparity_err;
    logic [1:0]  base_lane;
    logic        aligned;
    logic [1:0]  state;
    logic [15:0] realign_count;
    logic        comma_err;

    modport master (
        output rx_data_valid, rx_data_is_ctl, rx_data, rx_symbol_err, rx_disparity_err,
        input  base_lane, aligned, state, realign_count, comma_err
    );

    modport slave (
        input  rx_data_valid, rx_data_is_ctl, rx_data, rx_symbol_err, rx_disparity_err,
        output base_lane, aligned, state, realign_count, comma_err
    );
endinterface

// File: rtl/qsgmii_lane_align_ctrl.sv
// QSGMII lane-0 marker (K28.1) alignment: hunt/confirm/lock qualification of the
// base lane so a single stray comma or bit error cannot rotate the lane mapping.
module qsgmii_lane_align_ctrl #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned TIMEOUT      = 16383
) (
    input  logic                           clk,
    input  logic                           rst,
    qsgmii_lane_align_ctrl_if.slave        align_if
);
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MM_W   = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  K28_1  = 8'h3c;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_cand, w_cand_nxt;
    logic [1:0]        r_base_lane, w_base_lane_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [MM_W-1:0]   r_mm, w_mm_nxt, w_mm_inc;
    logic [TO_W-1:0]   r_to, w_to_nxt, w_to_inc;
    logic              r_aligned, w_aligned_nxt;
    logic [15:0]       r_realign_count, w_realign_count_nxt;
    logic              r_comma_err, w_comma_err_nxt;
    logic              w_unlock;

    logic [2:0]        w_nmatch;
    logic [1:0]        w_hitlane;
    logic              w_hit, w_multi;

    // Per-lane K28.1 detect; errored lanes never qualify.
    always_comb begin : comma_detect
        w_nmatch  = 3'd0;
        w_hitlane = 2'd0;
        for (int g = 0; g < LANES; g++) begin
            if (align_if.rx_data_is_ctl[g] && align_if.rx_data[g*8 +: 8] == K28_1 &&
                !align_if.rx_symbol_err[g] && !align_if.rx_disparity_err[g]) begin
                w_hitlane = 2'(g);
                w_nmatch  = w_nmatch + 3'd1;
            end
        end
    end

    assign w_hit   = (w_nmatch == 3'd1);
    assign w_multi = (w_nmatch > 3'd1);

    always_comb begin : next_state
        w_state_nxt         = r_state;
        w_cand_nxt          = r_cand;
        w_base_lane_nxt     = r_base_lane;
        w_cnt_nxt           = r_cnt;
        w_mm_nxt            = r_mm;
        w_to_nxt            = r_to;
        w_aligned_nxt       = r_aligned;
        w_realign_count_nxt = r_realign_count;
        w_comma_err_nxt     = 1'b0;
        w_unlock            = 1'b0;
        w_cnt_inc           = r_cnt + CNT_W'(1);
        w_mm_inc            = r_mm + MM_W'(1);
        w_to_inc            = r_to + TO_W'(1);

        if (align_if.rx_data_valid) begin
            unique case (r_state)
                ST_HUNT: begin
                    w_to_nxt = '0;
                    if (w_hit) begin
                        w_cand_nxt  = w_hitlane;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (w_hit) begin
                        w_to_nxt = '0;
                        if (w_hitlane == r_cand) begin
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(LOCK_COUNT)) begin
                                w_state_nxt     = ST_LOCKED;
                                w_base_lane_nxt = r_cand;
                                w_aligned_nxt   = 1'b1;
                                w_mm_nxt        = '0;
                            end
                        end else begin
                            w_cand_nxt = w_hitlane;
                            w_cnt_nxt  = CNT_W'(1);
                        end
                    end else if (w_multi) begin
                        w_state_nxt     = ST_HUNT;
                        w_comma_err_nxt = 1'b1;
                        w_to_nxt        = '0;
                    end else if (w_to_inc == TO_W'(TIMEOUT)) begin
                        w_state_nxt = ST_HUNT;
                        w_to_nxt    = '0;
                    end else begin
                        w_to_nxt = w_to_inc;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit && w_hitlane == r_base_lane) begin
                        w_mm_nxt = '0;
                        w_to_nxt = '0;
                    end else if (w_hit || w_multi) begin
                        w_comma_err_nxt = 1'b1;
                        w_mm_nxt        = w_mm_inc;
                        w_unlock        = (w_mm_inc == MM_W'(UNLOCK_COUNT));
                    end else if (w_to_inc == TO_W'(TIMEOUT)) begin
                        w_unlock = 1'b1;
                    end else begin
                        w_to_nxt = w_to_inc;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase

            // Mismatch and timeout share one exit so realign_count moves once.
            if (w_unlock) begin
                w_state_nxt   = ST_HUNT;
                w_aligned_nxt = 1'b0;
                w_to_nxt      = '0;
                w_mm_nxt      = '0;
                if (r_realign_count != 16'hffff) begin
                    w_realign_count_nxt = r_realign_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            r_state         <= ST_HUNT;
            r_cand          <= 2'd0;
            r_base_lane     <= 2'd0;
            r_cnt           <= '0;
            r_mm            <= '0;
            r_to            <= '0;
            r_aligned       <= 1'b0;
            r_realign_count <= 16'd0;
            r_comma_err     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cand          <= w_cand_nxt;
            r_base_lane     <= w_base_lane_nxt;
            r_cnt           <= w_cnt_nxt;
            r_mm            <= w_mm_nxt;
            r_to            <= w_to_nxt;
            r_aligned       <= w_aligned_nxt;
            r_realign_count <= w_realign_count_nxt;
            r_comma_err     <= w_comma_err_nxt;
        end
    end

    assign align_if.state         = r_state;
    assign align_if.base_lane     = r_base_lane;
    assign align_if.aligned       = r_aligned;
    assign align_if.realign_count = r_realign_count;
    assign align_if.comma_err     = r_comma_err;

endmodule

// File: tb/tb_qsgmii_lane_align_ctrl.sv
// Self-checking bench for qsgmii_lane_align_ctrl: directed scenarios plus random
// words, all compared against a word-level behavioural model.
module tb_qsgmii_lane_align_ctrl;
    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;
    localparam int TIMEOUT      = 16383;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    qsgmii_lane_align_ctrl_if u_if ();

    qsgmii_lane_align_ctrl #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .align_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0 = HUNT, 1 = CONFIRM, 2 = LOCKED
    int m_state, m_cand, m_cnt, m_mm, m_to, m_base, m_aligned, m_realign, m_cerr;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cand = 0; m_cnt = 0; m_mm = 0; m_to = 0;
        m_base = 0; m_aligned = 0; m_realign = 0; m_cerr = 0;
    endtask

    task automatic model_drop();
        m_state   = 0;
        m_aligned = 0;
        m_to      = 0;
        m_mm      = 0;
        if (m_realign < 65535) m_realign++;
    endtask

    task automatic model_step(input bit v, input logic [3:0] ctl, input logic [31:0] d,
                              input logic [3:0] se, input logic [3:0] de);
        int   lanes[$];
        logic [31:0] dd;
        m_cerr = 0;
        if (!v) return;
        dd = d;
        for (int g = 0; g < 4; g++)
            if (ctl[g] && dd[g*8 +: 8] == 8'h3c && !se[g] && !de[g]) lanes.push_back(g);
        if (m_state == 0) begin
            m_to = 0;
            if (lanes.size() == 1) begin
                m_state = 1; m_cand = lanes[0]; m_cnt = 1;
            end
        end else if (m_state == 1) begin
            if (lanes.size() == 1) begin
                m_to = 0;
                if (lanes[0] == m_cand) begin
                    m_cnt++;
                    if (m_cnt == LOCK_COUNT) begin
                        m_state = 2; m_base = m_cand; m_aligned = 1; m_mm = 0;
                    end
                end else begin
                    m_cand = lanes[0]; m_cnt = 1;
                end
            end else if (lanes.size() > 1) begin
                m_state = 0; m_cerr = 1; m_to = 0;
            end else begin
                m_to++;
                if (m_to == TIMEOUT) begin m_state = 0; m_to = 0; end
            end
        end else begin
            if (lanes.size() == 1 && lanes[0] == m_base) begin
                m_mm = 0; m_to = 0;
            end else if (lanes.size() >= 1) begin
                m_cerr = 1;
                m_mm++;
                if (m_mm == UNLOCK_COUNT) model_drop();
            end else begin
                m_to++;
                if (m_to == TIMEOUT) model_drop();
            end
        end
    endtask

    task automatic check_all();
        chk("state",     int'(u_if.state),         m_state);
        chk("aligned",   int'(u_if.aligned),       m_aligned);
        chk("base_lane", int'(u_if.base_lane),     m_base);
        chk("realign",   int'(u_if.realign_count), m_realign);
        chk("comma_err", int'(u_if.comma_err),     m_cerr);
    endtask

    function automatic logic [31:0] fill_data(input logic [3:0] k_lanes);
        logic [31:0] d;
        d = '0;
        for (int g = 0; g < 4; g++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (k_lanes[g]) b = 8'h3c;
            else if (b == 8'h3c) b = 8'h5a;
            d[g*8 +: 8] = b;
        end
        return d;
    endfunction

    task automatic cycle(input bit v, input logic [3:0] ctl, input logic [31:0] d,
                         input logic [3:0] se, input logic [3:0] de);
        @(negedge clk);
        u_if.rx_data_valid    = v;
        u_if.rx_data_is_ctl   = ctl;
        u_if.rx_data          = d;
        u_if.rx_symbol_err    = se;
        u_if.rx_disparity_err = de;
        model_step(v, ctl, d, se, de);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_k(input logic [3:0] lanes);
        cycle(1'b1, lanes, fill_data(lanes), 4'h0, 4'h0);
    endtask

    task automatic send_none();
        cycle(1'b1, 4'($urandom_range(0, 15)), fill_data(4'h0), 4'h0, 4'h0);
    endtask

    // Invalid cycle carrying a comma; it must have no effect.
    task automatic send_idle();
        cycle(1'b0, 4'b0100, fill_data(4'b0100), 4'h0, 4'h0);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, "_state"},   int'(u_if.state),         0);
        chk({tag, "_aligned"}, int'(u_if.aligned),       0);
        chk({tag, "_base"},    int'(u_if.base_lane),     0);
        chk({tag, "_realign"}, int'(u_if.realign_count), 0);
        chk({tag, "_cerr"},    int'(u_if.comma_err),     0);
        model_reset();
        u_if.rx_data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst = 1'b1;
        u_if.rx_data_valid    = 1'b0;
        u_if.rx_data_is_ctl   = 4'h0;
        u_if.rx_data          = 32'h0;
        u_if.rx_symbol_err    = 4'h0;
        u_if.rx_disparity_err = 4'h0;
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Lock on lane 2 with a hit every second valid word
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send_k(4'b0100);
            else            send_none();
            if (i == 0) chk("t1_confirm", int'(u_if.state), 1);
            if (i == 6) begin
                chk("t1_locked",  int'(u_if.state),     2);
                chk("t1_aligned", int'(u_if.aligned),   1);
                chk("t1_base",    int'(u_if.base_lane), 2);
            end
        end

        // Stray lane-1 commas, then a sustained lane-1 stream
        send_k(4'b0010);
        chk("t2_cerr1", int'(u_if.comma_err), 1);
        send_k(4'b0010);
        send_k(4'b0100);
        chk("t2_still_locked", int'(u_if.state), 2);
        repeat (3) send_k(4'b0010);
        chk("t2_hunt",    int'(u_if.state),         0);
        chk("t2_realign", int'(u_if.realign_count), 1);
        chk("t2_base",    int'(u_if.base_lane),     2);

        // Candidate switch in CONFIRM
        send_k(4'b0001);
        send_k(4'b0001);
        send_k(4'b1000);
        send_k(4'b1000);
        send_k(4'b1000);
        chk("t3_not_yet", int'(u_if.state), 1);
        send_k(4'b1000);
        chk("t3_locked", int'(u_if.state),     2);
        chk("t3_base",   int'(u_if.base_lane), 3);

        // Timeout with valid toggling
        for (int i = 1; i <= TIMEOUT; i++) begin
            send_none();
            if (i == TIMEOUT - 1) chk("t4_pre", int'(u_if.state), 2);
            if (i == TIMEOUT)     chk("t4_hunt", int'(u_if.state), 0);
            send_idle();
        end
        chk("t4_realign", int'(u_if.realign_count), 2);

        // Multi-comma handling in each state, and disparity-qualified lanes
        send_k(4'b0101);
        chk("t5_hunt_ignore", int'(u_if.state), 0);
        send_k(4'b0001);
        send_k(4'b0101);
        chk("t5_confirm_drop", int'(u_if.state),     0);
        chk("t5_confirm_cerr", int'(u_if.comma_err), 1);
        repeat (4) send_k(4'b0001);
        send_k(4'b0101);
        chk("t5_locked_cerr", int'(u_if.comma_err), 1);
        cycle(1'b1, 4'b0101, fill_data(4'b0101), 4'h0, 4'b0001);
        cycle(1'b1, 4'b0001, fill_data(4'b0001), 4'h0, 4'b0001);
        chk("t5_disp_nohit", int'(u_if.comma_err), 0);
        send_k(4'b0001);

        // Async reset mid-CONFIRM and while locked
        send_k(4'b0000);
        async_reset("t6a");
        send_k(4'b0010);
        send_k(4'b0010);
        async_reset("t6b");
        repeat (3) send_k(4'b0010);
        chk("t6_relock_pending", int'(u_if.state), 1);
        send_k(4'b0010);
        chk("t6_relocked", int'(u_if.state), 2);
        async_reset("t6c");

        // Random words; one lane favoured so locks actually occur
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] k, ctl, se, de;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45)      k = (($urandom_range(0, 9) < 8) ? 4'b0010 : 4'(1 << $urandom_range(0, 3)));
            else if (r < 55) k = 4'($urandom_range(0, 15));
            else             k = 4'h0;
            ctl = k | 4'($urandom_range(0, 15));
            se  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            de  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cycle(($urandom_range(0, 9) < 8), ctl, fill_data(k), se, de);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
